// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: fetch sequencer bus, covering the instruction memory port, redirect/halt control and the decode output slot.
interface fetch_sequencer_if;
    logic [31:0] address;
    logic [31:0] instruction;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] fetch_count;
    modport master (
        output address, out_valid, out_instr, out_pc, fetch_count,
        input  instruction, redirect_valid, redirect_pc, halt_req, out_ready
    );
    modport slave (
        input  address, out_valid, out_instr, out_pc, fetch_count,
        output instruction, redirect_valid, redirect_pc, halt_req, out_ready
    );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC sequencer with a one-entry output slot, redirect flush and halt.
// Define FETCH_COUNT_EN to build the accepted-instruction counter behind fetch_count.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input logic               clk,
    input logic               rst_n,
    fetch_sequencer_if.master bus
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, instr_q, instr_d, opc_q, opc_d;
    logic        valid_q, valid_d, handshake, capture;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= '0;
            opc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            opc_q   <= opc_d;
        end
    end
    // Every state leaves on the same halt rule; redirect never changes state.
    always_comb begin
        state_d   = bus.halt_req ? HALT : RUN;
        handshake = valid_q && bus.out_ready;
        capture   = state_q == RUN && !bus.halt_req && !bus.redirect_valid && (!valid_q || bus.out_ready);
        pc_d      = bus.redirect_valid ? {bus.redirect_pc[31:2], 2'b00} : capture ? pc_q + PC_STEP : pc_q;
        valid_d   = !bus.redirect_valid && (capture || (valid_q && !handshake));
        instr_d   = capture ? bus.instruction : instr_q;
        opc_d     = capture ? pc_q : opc_q;
    end
    assign bus.address   = pc_q;
    assign bus.out_valid = valid_q;
    assign bus.out_instr = instr_q;
    assign bus.out_pc    = opc_q;
`ifdef FETCH_COUNT_EN
    logic [31:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else if (handshake) cnt_q <= cnt_q + 32'd1;
    end
    assign bus.fetch_count = cnt_q;
`else
    assign bus.fetch_count = '0;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: random and directed stimulus; a scoreboard of expected fetch addresses is checked by a negedge monitor.
module tb_fetch_sequencer;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] STEP     = 32'd4;
`ifdef FETCH_COUNT_EN
    localparam bit FC = 1'b1;
`else
    localparam bit FC = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] nxt = RESET_PC;
    logic [31:0] exp_cnt = '0;
    logic [31:0] held;
    logic        p_stall = 1'b0;
    logic [31:0] p_pc, e;
    fetch_sequencer_if bus ();
    fetch_sequencer #(.RESET_PC(RESET_PC), .PC_STEP(STEP)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    // Instruction memory: the word at byte address N is N.
    assign bus.instruction = bus.address;
    function automatic void chk(input string n, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, got, want, $time);
        end
    endfunction
    // Accepted instructions form a consecutive stream restarted by reset or redirect.
    always @(negedge clk) begin
        if (rst_n) begin
            if (p_stall) begin
                chk("stall_valid", {31'b0, bus.out_valid}, 32'd1);
                chk("stall_pc", bus.out_pc, p_pc);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty: got out_pc %h expected none at %0t", bus.out_pc, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_pc", bus.out_pc, e);
                    chk("out_instr", bus.out_instr, e);
                    exp_cnt++;
                end
            end
            p_stall = bus.out_valid && !bus.out_ready && !bus.redirect_valid;
            p_pc    = bus.out_pc;
        end else p_stall = 1'b0;
    end
    task automatic tick();
        logic        rv;
        logic [31:0] rp;
        rv = bus.redirect_valid && rst_n;
        rp = bus.redirect_pc;
        @(posedge clk);
        #1;
        if (rv) begin
            exp_q.delete();
            nxt = {rp[31:2], 2'b00};
        end
        while (exp_q.size() < 8) begin
            exp_q.push_back(nxt);
            nxt += STEP;
        end
        chk("fetch_count", bus.fetch_count, FC ? exp_cnt : 32'd0);
    endtask
    task automatic do_reset();
        bus.redirect_valid = 1'b0;
        bus.halt_req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_address", bus.address, RESET_PC);
        chk("rst_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_out_pc", bus.out_pc, 32'd0);
        chk("rst_out_instr", bus.out_instr, 32'd0);
        chk("rst_count", bus.fetch_count, 32'd0);
        exp_q.delete();
        nxt = RESET_PC;
        exp_cnt = '0;
        tick();
        rst_n = 1'b1;
    endtask
    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.halt_req = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        do_reset();
        tick();
        chk("boot_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("boot_address", bus.address, 32'd0);
        tick();
        chk("first_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("first_pc", bus.out_pc, 32'd0);
        tick();
        chk("seq_pc4", bus.out_pc, 32'd4);
        tick();
        chk("seq_pc8", bus.out_pc, 32'd8);
        chk("seq_addr12", bus.address, 32'd12);
        bus.out_ready = 1'b0;
        repeat (3) begin
            tick();
            chk("hold_valid", {31'b0, bus.out_valid}, 32'd1);
            chk("hold_pc", bus.out_pc, 32'd8);
            chk("hold_instr", bus.out_instr, 32'd8);
            chk("hold_address", bus.address, 32'd12);
        end
        bus.out_ready = 1'b1;
        tick();
        chk("resume_pc12", bus.out_pc, 32'd12);
        bus.out_ready = 1'b0;
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0000_0103;
        tick();
        chk("flush_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("redir_address", bus.address, 32'h0000_0100);
        bus.redirect_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("redir_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("redir_pc", bus.out_pc, 32'h0000_0100);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFF8;
        tick();
        bus.redirect_valid = 1'b0;
        tick();
        chk("wrap_pc0", bus.out_pc, 32'hFFFF_FFF8);
        tick();
        chk("wrap_pc1", bus.out_pc, 32'hFFFF_FFFC);
        tick();
        chk("wrap_pc2", bus.out_pc, 32'h0000_0000);
        held = bus.address;
        bus.halt_req = 1'b1;
        repeat (5) begin
            tick();
            chk("halt_valid", {31'b0, bus.out_valid}, 32'd0);
            chk("halt_address", bus.address, held);
        end
        bus.halt_req = 1'b0;
        tick();
        chk("unhalt_valid", {31'b0, bus.out_valid}, 32'd0);
        tick();
        chk("unhalt_pc", bus.out_pc, held);
        do_reset();
        bus.out_ready = 1'b1;
        repeat (12) tick();
        chk("count_10", bus.fetch_count, FC ? 32'd10 : 32'd0);
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
                continue;
            end
            bus.out_ready = $urandom_range(0, 3) != 0;
            bus.redirect_valid = $urandom_range(0, 19) == 0;
            bus.redirect_pc = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom;
            if ($urandom_range(0, 24) == 0) bus.halt_req = !bus.halt_req;
            tick();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter PC_STEP, default 4, meaning the byte increment per sequential fetch.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port address, output, 32 bits: instruction memory address, equal to the PC register.
REQ-006 The block SHALL have port instruction, input, 32 bits: instruction memory data, combinational from address in the same cycle.
REQ-007 The block SHALL have port redirect_valid, input, 1 bit: branch/jump redirect request.
REQ-008 The block SHALL have port redirect_pc, input, 32 bits: redirect target.
REQ-009 The block SHALL have port halt_req, input, 1 bit: level request to stop fetching.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_instr/out_pc hold a fetched instruction.
REQ-011 The block SHALL have port out_ready, input, 1 bit: decode accepts the output this cycle.
REQ-012 The block SHALL have port out_instr, output, 32 bits: fetched instruction word.
REQ-013 The block SHALL have port out_pc, output, 32 bits: address out_instr was fetched from.
REQ-014 The block SHALL have port fetch_count, output, 32 bits: count of accepted instructions (see Configuration).

Function
REQ-015 The block SHALL implement FSM states BOOT, RUN and HALT; reset enters BOOT.
REQ-016 BOOT SHALL last exactly one cycle with no capture, then go to RUN (or to HALT if halt_req is 1).
REQ-017 In RUN, the output slot SHALL be "free" when out_valid is 0, or when out_valid and out_ready are both 1.
REQ-018 In RUN with the slot free and no redirect, the block SHALL register out_instr<=instruction, out_pc<=PC, out_valid<=1 and PC<=PC+PC_STEP.
REQ-019 In RUN with the slot not free, the block SHALL hold PC, out_instr, out_pc and out_valid stable (stall).
REQ-020 When the slot is free and nothing is captured, out_valid SHALL go to 0 after a handshake.
REQ-021 On redirect_valid=1 in any state, the block SHALL set PC<={redirect_pc[31:2],2'b00} and out_valid<=0 (flush), with no capture that cycle.
REQ-022 The flush SHALL discard a pending un-accepted output.
REQ-023 Redirect SHALL take priority over capture and stall.
REQ-024 halt_req=1 in RUN SHALL go to HALT with no capture that cycle; an already-valid output SHALL remain until handshaked.
REQ-025 In HALT, PC SHALL be held and no capture SHALL occur; halt_req=0 returns to RUN next cycle.
REQ-026 A redirect in HALT SHALL update PC while the block stays in HALT.
REQ-027 PC arithmetic SHALL be modulo 2^32, so 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-028 address SHALL equal PC at all times, with zero latency.
REQ-029 Fetch-to-output latency SHALL be 1 cycle; sustained throughput SHALL be 1 instruction per cycle when out_ready=1.

Reset
REQ-030 rst_n=0 SHALL asynchronously force PC=RESET_PC, out_valid=0, out_instr=0, out_pc=0, fetch_count=0 and state=BOOT.
REQ-031 Reset mid-stall or mid-redirect SHALL discard all state, and the first capture after release SHALL be from RESET_PC.

Configuration
REQ-032 With macro FETCH_COUNT_EN defined, fetch_count SHALL increment by 1 on each cycle where out_valid and out_ready are both 1, wrap at 2^32, and not be cleared by redirect.
REQ-033 Without FETCH_COUNT_EN, fetch_count SHALL be constant 0 and no counter register SHALL be synthesized.

Verification
REQ-034 The bench SHALL check: reset release, memory word at byte address N = N, out_ready=1 -> out_pc sequence 0,4,8,12 with out_instr equal to out_pc, first out_valid on the 2nd cycle after release.
REQ-035 The bench SHALL check: out_ready=0 for 3 cycles while out_pc=8 -> out_pc/out_instr stable for 3 cycles and address held at 12.
REQ-036 The bench SHALL check: redirect_valid with redirect_pc=32'h0000_0103 while an output is pending -> out_valid=0 next cycle, then out_pc=32'h100.
REQ-037 The bench SHALL check: redirect to 32'hFFFF_FFF8 -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-038 The bench SHALL check: halt_req held for 5 cycles -> no new capture and address frozen; after release, fetch resumes at the held address.
REQ-039 The bench SHALL check: with FETCH_COUNT_EN defined, 10 handshakes -> fetch_count=10; rst_n pulsed low mid-run -> fetch_count=0 and address=RESET_PC immediately.
